// File: rtl/cz80_alu16_pkg.sv
// Shared types and constants for the 16-bit sequenced Z80 arithmetic block.
package cz80_alu16_pkg;

    // Sequencer states: wait for a request, low byte, high byte, hold result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Request opcodes seen on req_op
    localparam logic [1:0] OP_ADD16 = 2'd0;
    localparam logic [1:0] OP_ADC16 = 2'd1;
    localparam logic [1:0] OP_SBC16 = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    // 8-bit ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SBC = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_CP  = 3'd7;

    // Bit positions inside the Z80 flag register
    localparam int FLAG_C  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_PV = 2;
    localparam int FLAG_X  = 3;
    localparam int FLAG_H  = 4;
    localparam int FLAG_Y  = 5;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_S  = 7;

    // 8-bit ALU op for one byte of a 16-bit request; ADD16 chains its high byte through ADC
    function automatic logic [2:0] alu_op_for(input logic [1:0] op, input logic high_byte);
        case (op)
            OP_ADC16: return ALU_ADC;
            OP_SBC16: return ALU_SBC;
            default:  return high_byte ? ALU_ADC : ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cz80_alu16_seq_alu.sv
// Z80 8-bit ALU: add/sub/logic group plus the CB-prefix rotate/shift/bit group.
module cz80_alu
    import cz80_alu16_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic       arith16,
    input  logic       z16,
    input  logic       alu_cpi,
    input  logic [1:0] iset,
    input  logic [7:3] ir,
    input  logic [7:0] busa,
    input  logic [7:0] busb,
    input  logic [7:0] f_in,
    output logic [7:0] q,
    output logic [7:0] f_out
);

    logic       is_sub;
    logic       cin;
    logic       cin_eff;
    logic [7:0] bus_b_eff;
    logic [8:0] byte_sum;
    logic [7:0] arith_r;
    logic       half;
    logic       carry;
    logic       ovf;
    logic [7:0] logic_r;
    logic [7:0] rot_r;
    logic       rot_c;
    logic [7:0] bit_mask;

    // Shared adder; subtraction is a + ~b + ~borrow, so borrows are inverted carries
    always_comb begin
        is_sub    = (alu_op == ALU_SUB) || (alu_op == ALU_SBC) || (alu_op == ALU_CP);
        cin       = ((alu_op == ALU_ADC) || (alu_op == ALU_SBC)) && f_in[FLAG_C];
        cin_eff   = is_sub ? ~cin : cin;
        bus_b_eff = is_sub ? ~busb : busb;
        byte_sum  = {1'b0, busa} + {1'b0, bus_b_eff} + {8'b0, cin_eff};
        arith_r   = byte_sum[7:0];
        half      = busa[4] ^ bus_b_eff[4] ^ arith_r[4] ^ is_sub;
        carry     = byte_sum[8] ^ is_sub;
        ovf       = (busa[7] == bus_b_eff[7]) && (arith_r[7] != busa[7]);
    end

    // Logic-group results and the rotate/shift results selected by opcode bits 5:3
    always_comb begin
        case (alu_op)
            ALU_AND: logic_r = busa & busb;
            ALU_XOR: logic_r = busa ^ busb;
            default: logic_r = busa | busb;
        endcase
        rot_c = busa[7];
        case (ir[5:3])
            3'd0:    rot_r = {busa[6:0], busa[7]};
            3'd1:    begin rot_r = {busa[0], busa[7:1]};        rot_c = busa[0]; end
            3'd2:    rot_r = {busa[6:0], f_in[FLAG_C]};
            3'd3:    begin rot_r = {f_in[FLAG_C], busa[7:1]};   rot_c = busa[0]; end
            3'd4:    rot_r = {busa[6:0], 1'b0};
            3'd5:    begin rot_r = {busa[7], busa[7:1]};        rot_c = busa[0]; end
            3'd6:    rot_r = {busa[6:0], 1'b1};
            default: begin rot_r = {1'b0, busa[7:1]};           rot_c = busa[0]; end
        endcase
        bit_mask = 8'h01 << ir[5:3];
    end

    // Result and flag selection; 16-bit ops either keep S/Z/PV or chain Z across bytes
    always_comb begin
        q     = busa;
        f_out = f_in;
        if (iset == 2'b01) begin
            case (ir[7:6])
                2'b00: begin
                    q     = rot_r;
                    f_out = {rot_r[7], (rot_r == 8'h00), rot_r[5], 1'b0,
                             rot_r[3], ~^rot_r, 1'b0, rot_c};
                end
                2'b01: begin
                    f_out[FLAG_Z]  = ~|(busa & bit_mask);
                    f_out[FLAG_PV] = ~|(busa & bit_mask);
                    f_out[FLAG_S]  = busa[7] & bit_mask[7];
                    f_out[FLAG_H]  = 1'b1;
                    f_out[FLAG_N]  = 1'b0;
                    f_out[FLAG_X]  = busa[3];
                    f_out[FLAG_Y]  = busa[5];
                end
                2'b10:   q = busa & ~bit_mask;
                default: q = busa | bit_mask;
            endcase
        end else if ((alu_op == ALU_AND) || (alu_op == ALU_XOR) || (alu_op == ALU_OR)) begin
            q     = logic_r;
            f_out = {logic_r[7], (logic_r == 8'h00), logic_r[5], (alu_op == ALU_AND),
                     logic_r[3], ~^logic_r, 1'b0, 1'b0};
        end else begin
            q              = (alu_op == ALU_CP) ? busa : arith_r;
            f_out[FLAG_C]  = alu_cpi ? f_in[FLAG_C] : carry;
            f_out[FLAG_H]  = half;
            f_out[FLAG_PV] = ovf;
            f_out[FLAG_N]  = is_sub;
            f_out[FLAG_S]  = arith_r[7];
            f_out[FLAG_Z]  = (arith_r == 8'h00) ? (z16 ? f_in[FLAG_Z] : 1'b1) : 1'b0;
            f_out[FLAG_X]  = (alu_op == ALU_CP) ? busb[3] : arith_r[3];
            f_out[FLAG_Y]  = (alu_op == ALU_CP) ? busb[5] : arith_r[5];
        end
        if (arith16) begin
            f_out[FLAG_S]  = f_in[FLAG_S];
            f_out[FLAG_Z]  = f_in[FLAG_Z];
            f_out[FLAG_PV] = f_in[FLAG_PV];
        end
    end

endmodule

// File: rtl/cz80_alu16_seq.sv
// 16-bit Z80 ADD/ADC/SBC HL,rr built from one 8-bit ALU, low byte then high byte.
module cz80_alu16_seq
    import cz80_alu16_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [7:0]  req_f,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_q,
    output logic [7:0]  res_f,
    output logic        err_op
);

    state_t      state;
    state_t      state_next;
    logic [15:0] a_lat;
    logic [15:0] b_lat;
    logic [7:0]  f_lat;
    logic [1:0]  op_lat;
    logic [7:0]  f_hold;
    logic        accept;
    logic [2:0]  alu_op;
    logic        arith16;
    logic        z16;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_fin;
    logic [7:0]  alu_q;
    logic [7:0]  alu_fout;

    assign accept = req_valid && req_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the ALU operand/control mux for the byte being worked on
    always_comb begin
        state_next = state;
        alu_op     = alu_op_for(op_lat, 1'b0);
        arith16    = (op_lat == OP_ADD16);
        z16        = 1'b0;
        alu_a      = a_lat[7:0];
        alu_b      = b_lat[7:0];
        alu_fin    = f_lat;
        case (state)
            IDLE: begin
                if (accept && (req_op != OP_RSVD)) begin
                    state_next = LO;
                end
            end
            LO: begin
                state_next = HI;
            end
            HI: begin
                state_next = DONE;
                alu_op     = alu_op_for(op_lat, 1'b1);
                z16        = (op_lat != OP_ADD16);
                alu_a      = a_lat[15:8];
                alu_b      = b_lat[15:8];
                alu_fin    = f_hold;
            end
            default: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Request latches, byte results and registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_lat     <= 16'h0000;
            b_lat     <= 16'h0000;
            f_lat     <= 8'h00;
            op_lat    <= OP_ADD16;
            f_hold    <= 8'h00;
            res_q     <= 16'h0000;
            res_f     <= 8'h00;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            err_op    <= 1'b0;
        end else begin
            req_ready <= (state_next == IDLE);
            res_valid <= (state_next == DONE);
            err_op    <= accept && (req_op == OP_RSVD);
            case (state)
                IDLE: begin
                    if (accept && (req_op != OP_RSVD)) begin
                        a_lat  <= req_a;
                        b_lat  <= req_b;
                        f_lat  <= req_f;
                        op_lat <= req_op;
                    end
                end
                LO: begin
                    res_q[7:0] <= alu_q;
                    f_hold     <= alu_fout;
                end
                HI: begin
                    res_q[15:8] <= alu_q;
                    res_f       <= alu_fout;
                end
                default: ;
            endcase
        end
    end

    cz80_alu u_alu (
        .alu_op  (alu_op),
        .arith16 (arith16),
        .z16     (z16),
        .alu_cpi (1'b0),
        .iset    (2'b00),
        .ir      (5'b00000),
        .busa    (alu_a),
        .busb    (alu_b),
        .f_in    (alu_fin),
        .q       (alu_q),
        .f_out   (alu_fout)
    );

endmodule
